ahbl_bus_xn: RTL and testbench
==============================

AHBL_BUS_XN -- requirements
Module: ahbl_bus_xn

Interface
REQ-001 The block SHALL have parameter N_SLV, default 5, giving the number of attached AHB-lite slaves (legal range 1..16).
REQ-002 The block SHALL have parameter DEC_MSB, default 31, the upper bit of the decoded HADDR region field.
REQ-003 The block SHALL have parameter DEC_LSB, default 24, the lower bit of the decoded HADDR region field; RW = DEC_MSB-DEC_LSB+1.
REQ-004 The block SHALL have parameter SLV_REGION, an N_SLV*RW packed region-code vector with slave i at bits [i*RW+:RW], default {0x40,0x20,0x10,0x01,0x00}.
REQ-005 The block SHALL have parameter TMO_CYC, default 255, the wait-state timeout in cycles; 0 disables the timeout.
REQ-006 HCLK  in  1  single clock; every flop is clocked on its rising edge.
REQ-007 HRESET  in  1  reset, synchronous and active-high.
REQ-008 HADDR  in  32  master address.
REQ-009 HTRANS  in  2  master transfer type.
REQ-010 HREADY  out  1  bus ready, returned to the master and to all slaves.
REQ-011 HRDATA  out  32  read data to the master.
REQ-012 HRESP  out  1  response to the master: 0 = OKAY, 1 = ERROR.
REQ-013 HSEL_S  out  N_SLV  per-slave select.
REQ-014 HREADYOUT_S  in  N_SLV  per-slave ready.
REQ-015 HRDATA_S  in  N_SLV*32  per-slave read data; slave i at [i*32+:32].
REQ-016 HRESP_S  in  N_SLV  per-slave response.
REQ-017 tmo_irq  out  1  sticky timeout flag.
REQ-018 tmo_addr  out  32  HADDR of the transfer that timed out.
REQ-019 tmo_clr  in  1  single-cycle clear of tmo_irq.

Function
REQ-020 HSEL_S[i] SHALL be combinational: 1 when HADDR[DEC_MSB:DEC_LSB]==SLV_REGION[i], regardless of HTRANS.
REQ-021 If more than one region matches, only the lowest-index match SHALL be driven high.
REQ-022 If no region matches, the internal default slave SHALL be selected.
REQ-023 On each cycle with HREADY=1, the block SHALL register the data-phase select (N_SLV+1 one-hot), HTRANS[1] as act_q, and HADDR as addr_q.
REQ-024 With the control FSM in ST_OK and a real slave selected, HREADY, HRDATA and HRESP SHALL be that slave's HREADYOUT_S, HRDATA_S and HRESP_S, passed through combinationally.
REQ-025 In ST_OK with the default slave selected and act_q=0, the block SHALL drive HREADY=1, HRESP=0, HRDATA=0.
REQ-026 The control FSM SHALL have states ST_OK, ST_ERR1 and ST_ERR2.
REQ-027 ST_OK -> ST_ERR1 SHALL occur when the default slave is selected with act_q=1, or when the timeout fires.
REQ-028 ST_ERR1 SHALL drive HREADY=0, HRESP=1 and go to ST_ERR2 on the next cycle.
REQ-029 ST_ERR2 SHALL drive HREADY=1, HRESP=1 and go to ST_OK on the next cycle.
REQ-030 HRDATA SHALL be 0 in ST_ERR1 and ST_ERR2.
REQ-031 Timeout counter (8..16 bits, sized to TMO_CYC) behaviour:
- clears when HREADY=1;
- otherwise increments while in ST_OK with act_q=1 and the selected slave's HREADYOUT=0.
REQ-032 When the counter equals TMO_CYC-1 and the slave is still not ready, the block SHALL enter ST_ERR1, set tmo_irq=1 and load tmo_addr<=addr_q in that cycle.
REQ-033 During ST_ERR1/ST_ERR2 entered by timeout, the stalled slave's HREADYOUT_S and HRESP_S SHALL be ignored.
REQ-034 After a timeout, recovery of the stalled slave is a software responsibility.
REQ-035 If tmo_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-036 While tmo_irq=1, tmo_addr SHALL hold the first fault address; a later timeout SHALL NOT overwrite it until tmo_clr.
REQ-037 In ST_OK, a slave-originated ERROR SHALL be passed through unmodified.
REQ-038 Latency: the block SHALL add zero wait states to real-slave transfers, and the default slave SHALL take exactly 2 cycles per active transfer.

Reset
REQ-039 While HRESET=1 at a rising HCLK edge, the block SHALL clear state: FSM=ST_OK, select=none, act_q=0, counter=0, tmo_irq=0, tmo_addr=0.
REQ-040 After reset the block SHALL drive HREADY=1, HRESP=0, HRDATA=0.
REQ-041 Reset asserted mid-transfer or in ST_ERR1/ST_ERR2 SHALL abandon the transfer with no further ERROR cycle.
REQ-042 HSEL_S SHALL remain purely combinational from HADDR.

Structure
REQ-043 Shared package ahbl_pkg SHALL hold the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), the HRESP codes and the FSM state typedef.
REQ-044 One sub-module, ahbl_err_resp, SHALL implement the two-cycle ERROR sequencer, triggered by a start pulse and shared by the default-slave and timeout paths.
REQ-045 Decode and the data-phase multiplexer SHALL remain in the top level.

Verification
REQ-046 Read HADDR=0x2000_0010 with slave 2 returning 0xDEAD_BEEF after 3 wait states -> HSEL_S=0b00100, HREADY low for 3 cycles, HRDATA=0xDEADBEEF, HRESP=0.
REQ-047 NONSEQ to 0x7F00_0000 (unmapped) -> HREADY=0/HRESP=1 for one cycle, then HREADY=1/HRESP=1, then ST_OK.
REQ-048 IDLE to 0x7F00_0000 -> zero-wait OKAY with no ERROR.
REQ-049 TMO_CYC=4, slave 1 holding HREADYOUT=0 on access to 0x1000_0004 -> 4 stall cycles, then a two-cycle ERROR, tmo_irq=1, tmo_addr=0x1000_0004.
REQ-050 Second timeout at 0x0100_0000 without tmo_clr -> tmo_addr stays 0x1000_0004; tmo_clr together with a third timeout -> tmo_irq stays 1.
REQ-051 HRESET pulsed while in ST_ERR1 -> the next cycle shows HREADY=1, HRESP=0, tmo_irq=0.

Source files
------------

// File: rtl/ahbl_bus_xn_pkg.sv
// Shared AHB-lite codes and the error-sequencer state type used by the
// ahbl_bus_xn decoder/multiplexer slice.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_st_e;

    // Timeout counter width: wide enough for TMO_CYC, clamped to 8..16 bits.
    function automatic int tmo_cnt_w(input int tmo_cyc);
        int w;
        w = $clog2(tmo_cyc + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/ahbl_bus_xn_if.sv
// AHB-lite master-side bus plus the per-slave select/response bundle.
// The decoder uses the slave modport; the environment uses master.
interface ahbl_bus_xn_if #(
    parameter int N_SLV = 5
);
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HREADY;
    logic [31:0]         HRDATA;
    logic                HRESP;
    logic [N_SLV-1:0]    HSEL_S;
    logic [N_SLV-1:0]    HREADYOUT_S;
    logic [N_SLV*32-1:0] HRDATA_S;
    logic [N_SLV-1:0]    HRESP_S;

    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
        output HREADY, HRDATA, HRESP, HSEL_S
    );

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
        input  HREADY, HRDATA, HRESP, HSEL_S
    );
endinterface

// File: rtl/ahbl_bus_xn_err_resp.sv
// Two-cycle AHB ERROR sequencer shared by the default-slave and timeout paths.
//   state   | meaning
//   ST_OK   | no error in progress, bus driven by the data-phase mux
//   ST_ERR1 | first ERROR cycle: HREADY=0, HRESP=ERROR
//   ST_ERR2 | second ERROR cycle: HREADY=1, HRESP=ERROR
module ahbl_err_resp
    import ahbl_pkg::*;
(
    input  logic    HCLK,
    input  logic    HRESET,
    input  logic    start,
    output err_st_e st,
    output logic    err_hready
);

    err_st_e st_nxt;

    always_ff @(posedge HCLK) begin
        if (HRESET) st <= ST_OK;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt     = st;
        err_hready = 1'b1;
        case (st)
            ST_OK:   if (start) st_nxt = ST_ERR1;
            ST_ERR1: begin
                err_hready = 1'b0;
                st_nxt     = ST_ERR2;
            end
            // An unmapped access accepted in ERR2's ready cycle chains into a fresh error.
            ST_ERR2: st_nxt = start ? ST_ERR1 : ST_OK;
            default: st_nxt = ST_OK;
        endcase
    end

endmodule

// File: rtl/ahbl_bus_xn.sv
// AHB-lite address decoder and data-phase multiplexer with an internal
// default slave and a wait-state timeout that reports the stalled address.
module ahbl_bus_xn
    import ahbl_pkg::*;
#(
    parameter int N_SLV   = 5,
    parameter int DEC_MSB = 31,
    parameter int DEC_LSB = 24,
    parameter logic [N_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_REGION =
        {8'h40, 8'h20, 8'h10, 8'h01, 8'h00},
    parameter int TMO_CYC = 255
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahbl_bus_xn_if.slave  bus,
    output logic          tmo_irq,
    output logic [31:0]   tmo_addr,
    input  logic          tmo_clr
);

    localparam int RW = DEC_MSB - DEC_LSB + 1;
    localparam int CW = tmo_cnt_w(TMO_CYC);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    logic [RW-1:0]    region;
    logic [N_SLV-1:0] hsel;
    logic             hit_any;
    logic             dflt_hit;

    logic [N_SLV:0]   sel_q;
    logic             act_q;
    logic [31:0]      addr_q;

    logic             slv_sel;
    logic             slv_rdy;
    logic             slv_resp;
    logic [31:0]      slv_rdata;

    err_st_e          st;
    logic             err_hready;
    logic             err_start;

    logic [CW-1:0]    tmo_cnt;
    logic             stall;
    logic             tmo_fire;

    assign region = bus.HADDR[DEC_MSB:DEC_LSB];

    // Lowest-index region wins when codes overlap.
    always_comb begin
        hsel    = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!hit_any && region == SLV_REGION[i*RW +: RW]) begin
                hsel[i] = 1'b1;
                hit_any = 1'b1;
            end
        end
    end

    assign dflt_hit   = ~hit_any;
    assign bus.HSEL_S = hsel;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q  <= '0;
            act_q  <= 1'b0;
            addr_q <= '0;
        end else if (bus.HREADY) begin
            sel_q  <= {dflt_hit, hsel};
            act_q  <= bus.HTRANS[1];
            addr_q <= bus.HADDR;
        end
    end

    always_comb begin
        slv_sel   = 1'b0;
        slv_rdy   = 1'b1;
        slv_resp  = HRESP_OKAY;
        slv_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                slv_sel   = 1'b1;
                slv_rdy   = bus.HREADYOUT_S[i];
                slv_resp  = bus.HRESP_S[i];
                slv_rdata = bus.HRDATA_S[i*32 +: 32];
            end
        end
    end

    // Outside ST_OK the sequencer owns the bus, so a stalled slave is ignored.
    always_comb begin
        if (st != ST_OK) begin
            bus.HREADY = err_hready;
            bus.HRESP  = HRESP_ERROR;
            bus.HRDATA = '0;
        end else if (slv_sel) begin
            bus.HREADY = slv_rdy;
            bus.HRESP  = slv_resp;
            bus.HRDATA = slv_rdata;
        end else begin
            bus.HREADY = 1'b1;
            bus.HRESP  = HRESP_OKAY;
            bus.HRDATA = '0;
        end
    end

    assign stall     = (st == ST_OK) && act_q && slv_sel && !slv_rdy;
    assign tmo_fire  = (TMO_CYC != 0) && stall && (tmo_cnt == TMO_LAST);
    // Default-slave errors launch as the address phase is accepted so the
    // data phase is exactly ERR1 then ERR2.
    assign err_start = tmo_fire || (bus.HREADY && dflt_hit && bus.HTRANS[1]);

    always_ff @(posedge HCLK) begin
        if (HRESET)          tmo_cnt <= '0;
        else if (bus.HREADY) tmo_cnt <= '0;
        else if (stall)      tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tmo_irq  <= 1'b0;
            tmo_addr <= '0;
        end else if (tmo_fire) begin
            tmo_irq <= 1'b1;
            if (!tmo_irq) tmo_addr <= addr_q;
        end else if (tmo_clr) begin
            tmo_irq <= 1'b0;
        end
    end

    ahbl_err_resp u_err_resp (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (err_start),
        .st         (st),
        .err_hready (err_hready)
    );

endmodule

// File: tb/tb_ahbl_bus_xn.sv
// Scoreboard bench for ahbl_bus_xn: expected transfer results are queued at
// the address phase and compared when the data phase completes.
module tb_ahbl_bus_xn;
    import ahbl_pkg::*;

    localparam int N   = 5;
    localparam int TMO = 4;
    // slave0=0x01, slave1=0x10, slave2=0x20, slave3=0x00, slave4=0x10 (shadowed by slave1)
    localparam logic [N*8-1:0] MAP = {8'h10, 8'h00, 8'h20, 8'h10, 8'h01};

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        tmo_irq;
    logic [31:0] tmo_addr;
    logic        tmo_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahbl_bus_xn_if #(.N_SLV(N)) bus ();

    ahbl_bus_xn #(
        .N_SLV      (N),
        .DEC_MSB    (31),
        .DEC_LSB    (24),
        .SLV_REGION (MAP),
        .TMO_CYC    (TMO)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus.slave),
        .tmo_irq  (tmo_irq),
        .tmo_addr (tmo_addr),
        .tmo_clr  (tmo_clr)
    );

    task automatic slaves_idle();
        bus.HREADYOUT_S = '1;
        bus.HRESP_S     = '0;
        for (int i = 0; i < N; i++) bus.HRDATA_S[i*32 +: 32] = 32'hA5A5_0000 + i;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        bus.HADDR  = 32'h7F00_0000;
        bus.HTRANS = HTRANS_IDLE;
        slaves_idle();
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        checks++;
        if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: hready=%b hresp=%b hrdata=%h want 1 0 0", bus.HREADY, bus.HRESP, bus.HRDATA);
        end
        checks++;
        if (tmo_irq !== 1'b0 || tmo_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_tmo: irq=%b addr=%h want 0 0", tmo_irq, tmo_addr);
        end
    endtask

    // One transfer with an IDLE following it; slv<0 means unmapped.
    task automatic xfer(input logic [31:0] addr, input logic [1:0] trans, input int slv,
                        input int waits, input logic [31:0] data, input logic err,
                        input logic clr, input string name);
        exp_t e;
        logic [N-1:0] exp_sel;
        int k;
        @(posedge HCLK);
        #1;
        bus.HADDR  = addr;
        bus.HTRANS = trans;
        e.name = name;
        if (slv < 0) begin
            e.rdata = 32'h0; e.resp = trans[1]; e.waits = trans[1] ? 1 : 0;
        end else if (!trans[1]) begin
            e.rdata = 32'hA5A5_0000 + slv; e.resp = 1'b0; e.waits = 0;
        end else if (waits >= TMO) begin
            e.rdata = 32'h0; e.resp = 1'b1; e.waits = TMO + 1;
        end else begin
            e.rdata = data; e.resp = err; e.waits = waits;
        end
        sb.push_back(e);
        exp_sel = (slv < 0) ? '0 : (N'(1) << slv);
        #1;
        checks++;
        if (bus.HSEL_S !== exp_sel) begin
            failures++;
            $display("FAIL %s_hsel: got %b want %b", name, bus.HSEL_S, exp_sel);
        end
        @(posedge HCLK);
        #1;
        bus.HADDR  = 32'h7F00_0000;
        bus.HTRANS = HTRANS_IDLE;
        k = 0;
        forever begin
            if (slv >= 0 && trans[1]) begin
                bus.HREADYOUT_S[slv] = (k >= waits);
                bus.HRESP_S[slv]     = err && (k >= waits - 1);
                bus.HRDATA_S[slv*32 +: 32] = data;
            end
            tmo_clr = clr && (k == TMO - 1);
            @(negedge HCLK);
            if (bus.HREADY === 1'b1) break;
            if (slv < 0) begin
                checks++;
                if (bus.HRESP !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_err1: hresp=%b want 1", name, bus.HRESP);
                end
            end
            k++;
            if (k > 40) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: hready stuck low after %0d cycles", name, k);
                break;
            end
            @(posedge HCLK);
            #1;
        end
        tmo_clr = 1'b0;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_sb: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (k !== e.waits || bus.HRDATA !== e.rdata || bus.HRESP !== e.resp) begin
                failures++;
                $display("FAIL %s: waits=%0d hrdata=%h hresp=%b want waits=%0d hrdata=%h hresp=%b",
                         e.name, k, bus.HRDATA, bus.HRESP, e.waits, e.rdata, e.resp);
            end
        end
        @(posedge HCLK);
        #1;
        slaves_idle();
    endtask

    task automatic test_read_wait();
        xfer(32'h2000_0010, HTRANS_NONSEQ, 2, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd_s2_w3");
        xfer(32'h1000_0000, HTRANS_NONSEQ, 1, 0, 32'h1234_5678, 1'b0, 1'b0, "rd_overlap_s1");
        xfer(32'h00FF_FFFC, HTRANS_SEQ, 3, 2, 32'h0BAD_F00D, 1'b0, 1'b0, "rd_s3_seq");
    endtask

    task automatic test_slave_error();
        xfer(32'h2000_0020, HTRANS_NONSEQ, 2, 1, 32'h5555_AAAA, 1'b1, 1'b0, "slv_err");
    endtask

    task automatic test_unmapped();
        xfer(32'h7F00_0000, HTRANS_NONSEQ, -1, 0, 32'h0, 1'b0, 1'b0, "unmapped_nonseq");
        checks++;
        if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_recover: hready=%b hresp=%b want 1 0", bus.HREADY, bus.HRESP);
        end
        xfer(32'h7F00_0000, HTRANS_IDLE, -1, 0, 32'h0, 1'b0, 1'b0, "unmapped_idle");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[4];
        int slvs[4];
        exp_t e;
        addrs[0] = 32'h0100_0040; slvs[0] = 0;
        addrs[1] = 32'h1000_0000; slvs[1] = 1;
        addrs[2] = 32'h2000_0010; slvs[2] = 2;
        addrs[3] = 32'h0000_0008; slvs[3] = 3;
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK);
            #1;
            if (i < 4) begin
                bus.HADDR  = addrs[i];
                bus.HTRANS = HTRANS_NONSEQ;
                e.rdata = 32'hA5A5_0000 + slvs[i]; e.resp = 1'b0; e.waits = 0; e.name = "b2b";
                sb.push_back(e);
            end else begin
                bus.HADDR  = 32'h7F00_0000;
                bus.HTRANS = HTRANS_IDLE;
            end
            @(negedge HCLK);
            if (i > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.HREADY !== 1'b1 || bus.HRDATA !== e.rdata || bus.HRESP !== e.resp) begin
                    failures++;
                    $display("FAIL b2b_%0d: hready=%b hrdata=%h hresp=%b want 1 %h %b",
                             i, bus.HREADY, bus.HRDATA, bus.HRESP, e.rdata, e.resp);
                end
            end
        end
    endtask

    task automatic check_tmo(input logic irq, input logic [31:0] addr, input string name);
        checks++;
        if (tmo_irq !== irq || tmo_addr !== addr) begin
            failures++;
            $display("FAIL %s: irq=%b addr=%h want irq=%b addr=%h", name, tmo_irq, tmo_addr, irq, addr);
        end
    endtask

    task automatic test_timeout();
        xfer(32'h1000_0004, HTRANS_NONSEQ, 1, 1000, 32'h0, 1'b0, 1'b0, "tmo_first");
        check_tmo(1'b1, 32'h1000_0004, "tmo_first_flag");
        xfer(32'h0100_0000, HTRANS_NONSEQ, 0, 1000, 32'h0, 1'b0, 1'b0, "tmo_second");
        check_tmo(1'b1, 32'h1000_0004, "tmo_addr_hold");
        xfer(32'h0100_0000, HTRANS_NONSEQ, 0, 1000, 32'h0, 1'b0, 1'b1, "tmo_third_clr");
        check_tmo(1'b1, 32'h1000_0004, "tmo_set_wins");
        @(posedge HCLK);
        #1 tmo_clr = 1'b1;
        @(posedge HCLK);
        #1 tmo_clr = 1'b0;
        check_tmo(1'b0, 32'h1000_0004, "tmo_clr");
        xfer(32'h0100_0000, HTRANS_NONSEQ, 0, 1000, 32'h0, 1'b0, 1'b0, "tmo_fourth");
        check_tmo(1'b1, 32'h0100_0000, "tmo_recapture");
    endtask

    task automatic test_reset_in_err();
        @(posedge HCLK);
        #1;
        bus.HADDR  = 32'h7F00_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        @(posedge HCLK);
        #1;
        bus.HTRANS = HTRANS_IDLE;
        HRESET = 1'b1;
        @(negedge HCLK);
        checks++;
        if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin
            failures++;
            $display("FAIL rst_err1_entry: hready=%b hresp=%b want 0 1", bus.HREADY, bus.HRESP);
        end
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checks++;
            if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || tmo_irq !== 1'b0 || tmo_addr !== 32'h0) begin
                failures++;
                $display("FAIL rst_in_err_%0d: hready=%b hresp=%b irq=%b addr=%h want 1 0 0 0",
                         i, bus.HREADY, bus.HRESP, tmo_irq, tmo_addr);
            end
            @(posedge HCLK);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_slave_error();
        test_unmapped();
        test_back_to_back();
        test_timeout();
        test_reset_in_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
